// File: rtl/alu_writeback_pkg.sv
// Shared CPU definitions: destination/jump bit positions, stage states
// and the default datapath widths used by the writeback stage.
package alu_writeback_pkg;

  // Default datapath widths
  localparam int D_W_DEF = 16;
  localparam int A_W_DEF = 15;

  // Bit positions inside the {A,D,M} destination field
  localparam int DST_A = 2;
  localparam int DST_D = 1;
  localparam int DST_M = 0;

  // Bit positions inside the {lt,eq,gt} jump field
  localparam int JLT = 2;
  localparam int JEQ = 1;
  localparam int JGT = 0;

  // Writeback stage states: IDLE accepts, BUSY drains pending outputs
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } wbState_t;

endpackage

// File: rtl/alu_writeback_jmp_cond.sv
// Jump condition evaluation from the {lt,eq,gt} bits and the ALU flags.
// Purely combinational so the fetch predictor can reuse it unchanged.
module jmp_cond
  import alu_writeback_pkg::*;
(
  input  logic [2:0] i_jmp,
  input  logic       i_zr,
  input  logic       i_ng,
  output logic       o_taken
);

  logic w_lt;
  logic w_eq;
  logic w_gt;

  // Decode the sign/zero flags into the three orderings and OR the selected ones
  always_comb begin
    w_lt    = i_ng;
    w_eq    = i_zr;
    w_gt    = ~i_ng & ~i_zr;
    o_taken = (i_jmp[JLT] & w_lt) | (i_jmp[JEQ] & w_eq) | (i_jmp[JGT] & w_gt);
  end

endmodule

// File: rtl/alu_writeback.sv
// Writeback stage behind the ALU: commits the A and D registers, issues
// memory writes for M destinations, resolves jumps into a next-PC redirect
// and tracks a sticky overflow flag.
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int D_W = D_W_DEF,
  parameter int A_W = A_W_DEF
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           vld_s,
  output logic           rdy_s,
  input  logic [D_W-1:0] out_s,
  input  logic           zr_s,
  input  logic           ng_s,
  input  logic           of_s,
  input  logic           imm_s,
  input  logic [2:0]     dst_s,
  input  logic [2:0]     jmp_s,
  input  logic [A_W-1:0] pc_s,
  output logic [D_W-1:0] a_q,
  output logic [D_W-1:0] d_q,
  output logic           mw_vld_m,
  input  logic           mw_rdy_m,
  output logic [A_W-1:0] mw_addr_m,
  output logic [D_W-1:0] mw_data_m,
  output logic           pc_vld_m,
  input  logic           pc_rdy_m,
  output logic [A_W-1:0] pc_m,
  output logic           of_sticky,
  input  logic           of_clr
);

  wbState_t       r_state;
  wbState_t       w_nextState;
  logic           r_mwPend;
  logic           r_pcPend;
  logic           w_mwPendNext;
  logic           w_pcPendNext;

  logic [D_W-1:0] r_a;
  logic [D_W-1:0] r_d;
  logic [A_W-1:0] r_mwAddr;
  logic [D_W-1:0] r_mwData;
  logic [A_W-1:0] r_pc;
  logic           r_ofSticky;

  logic           w_accept;
  logic           w_mwWrite;
  logic           w_condTaken;
  logic           w_taken;
  logic           w_mwAck;
  logic           w_pcAck;
  logic [A_W-1:0] w_aAddr;
  logic [A_W-1:0] w_pcInc;

  jmp_cond u_jmpCond (
    .i_jmp   (jmp_s),
    .i_zr    (zr_s),
    .i_ng    (ng_s),
    .o_taken (w_condTaken)
  );

  // Handshake decode; ready comes from state only so it never loops back through vld_s
  always_comb begin
    rdy_s     = (r_state == IDLE);
    w_accept  = vld_s & rdy_s;
    w_mwWrite = ~imm_s & dst_s[DST_M];
    w_taken   = ~imm_s & w_condTaken;
    w_mwAck   = r_mwPend & mw_rdy_m;
    w_pcAck   = r_pcPend & pc_rdy_m;
    w_aAddr   = r_a[A_W-1:0];
    w_pcInc   = pc_s + A_W'(1);
  end

  // Next-state and pending-flag logic: BUSY lasts until both outputs are acknowledged
  always_comb begin
    w_nextState  = r_state;
    w_mwPendNext = r_mwPend;
    w_pcPendNext = r_pcPend;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState  = BUSY;
          w_mwPendNext = w_mwWrite;
          w_pcPendNext = 1'b1;
        end
      end
      BUSY: begin
        if (w_mwAck) begin
          w_mwPendNext = 1'b0;
        end
        if (w_pcAck) begin
          w_pcPendNext = 1'b0;
        end
        if (!w_mwPendNext && !w_pcPendNext) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState  = IDLE;
        w_mwPendNext = 1'b0;
        w_pcPendNext = 1'b0;
      end
    endcase
  end

  // State register and pending flags; reset drops any outstanding write or redirect
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_mwPend <= 1'b0;
      r_pcPend <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_mwPend <= w_mwPendNext;
      r_pcPend <= w_pcPendNext;
    end
  end

  // Commit A/D and capture write/redirect payloads; these only move on accept,
  // so they stay stable while BUSY waits for the downstream ready signals
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_a      <= '0;
      r_d      <= '0;
      r_mwAddr <= '0;
      r_mwData <= '0;
      r_pc     <= '0;
    end else if (w_accept) begin
      if (imm_s) begin
        r_a <= out_s;
      end else begin
        if (dst_s[DST_A]) begin
          r_a <= out_s;
        end
        if (dst_s[DST_D]) begin
          r_d <= out_s;
        end
      end
      if (w_mwWrite) begin
        r_mwAddr <= w_aAddr;
        r_mwData <= out_s;
      end
      r_pc <= w_taken ? w_aAddr : w_pcInc;
    end
  end

  // Sticky overflow: a new overflow on accept outranks a simultaneous clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ofSticky <= 1'b0;
    end else if (w_accept && !imm_s && of_s) begin
      r_ofSticky <= 1'b1;
    end else if (of_clr) begin
      r_ofSticky <= 1'b0;
    end
  end

  // Drive the output ports from the internal registers
  always_comb begin
    a_q       = r_a;
    d_q       = r_d;
    mw_vld_m  = r_mwPend;
    mw_addr_m = r_mwAddr;
    mw_data_m = r_mwData;
    pc_vld_m  = r_pcPend;
    pc_m      = r_pc;
    of_sticky = r_ofSticky;
  end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Stage directly downstream of the CPU ALU; consumes its result through the valid/ready handshake.
- Owns the architectural A and D registers, which feed the operand stage.
- Resolves jump conditions and issues the next-PC redirect to fetch.
- Issues data-memory writes for M destinations and keeps a sticky overflow status bit.

Parameters:
- D_W, 16, data/register width
- A_W, 15, instruction/data address width

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- vld_s  in  1  ALU result valid
- rdy_s  out  1  stage ready to accept
- out_s  in  D_W  ALU result (or immediate when imm_s=1)
- zr_s  in  1  result==0
- ng_s  in  1  result<0
- of_s  in  1  ALU carry/overflow
- imm_s  in  1  A-instruction: load out_s into A, no jump, no M write
- dst_s  in  3  {A,D,M} destination bits
- jmp_s  in  3  {lt,eq,gt} jump bits
- pc_s  in  A_W  address of this instruction
- a_q  out  D_W  A register
- d_q  out  D_W  D register
- mw_vld_m  out  1  memory write valid
- mw_rdy_m  in  1  memory write ready
- mw_addr_m  out  A_W  write address
- mw_data_m  out  D_W  write data
- pc_vld_m  out  1  next-PC valid
- pc_rdy_m  in  1  fetch ready
- pc_m  out  A_W  next PC
- of_sticky  out  1  sticky overflow flag
- of_clr  in  1  clear sticky flag

Behaviour:
- Clock is clk; reset rstn is asynchronous, active-low.
- Reset values:
  - a_q=0, d_q=0, pc_m=0, mw_addr_m=0, mw_data_m=0
  - mw_vld_m=0, pc_vld_m=0, of_sticky=0
  - state IDLE
- States:
  - IDLE: rdy_s=1.
  - BUSY: rdy_s=0. Two pending flags, mw_pend and pc_pend; mw_vld_m=mw_pend, pc_vld_m=pc_pend.
- Accept: vld_s & rdy_s at edge t.
  - A/D write:
    - imm_s=1: a_q<=out_s.
    - imm_s=0: if dst[2] a_q<=out_s; if dst[1] d_q<=out_s.
  - M write: if imm_s=0 & dst[0], mw_pend<=1, mw_addr_m<=a_q[A_W-1:0] sampled before the A update, mw_data_m<=out_s.
  - Jump decision: taken = ~imm_s & ((jmp[2]&ng_s) | (jmp[1]&zr_s) | (jmp[0]&~ng_s&~zr_s)).
  - Next PC: pc_m <= taken ? pre-update a_q[A_W-1:0] : pc_s+1. The +1 wraps modulo 2^A_W (max -> 0).
  - pc_pend<=1 always on accept.
  - Go to BUSY.
- Overflow: of_sticky<=1 on accept when imm_s=0 & f-path overflow (of_s=1).
  - of_clr clears it.
  - of_clr and a set in the same cycle: set wins.
- Handshakes in BUSY:
  - Each pending flag clears on its own vld&rdy edge; the two may complete in either order or the same cycle.
  - BUSY -> IDLE on the edge where the last pending flag clears. rdy_s rises the following cycle.
  - Minimum throughput: 1 instruction per 2 cycles.
- Output stability: mw_addr_m/mw_data_m/pc_m are held stable while the corresponding valid is high and unacknowledged.
- Hazard: updated a_q/d_q are visible the cycle after accept, before the stage is ready again, so upstream always sees committed A/D.
- Reset mid-operation: pending writes and redirects are dropped; registers return to reset values.
- rdy_s does not depend combinationally on vld_s; it is driven from state only.

Decomposition:
- Shared cpu package:
  - dst and jmp bit-index constants (DST_A=2, DST_D=1, DST_M=0, JLT=2, JEQ=1, JGT=0)
  - state enum typedef {IDLE, BUSY}
  - D_W/A_W defaults
- Sub-module jmp_cond: combinational taken-evaluation from jmp/zr/ng. It is reusable by the fetch predictor.

Test Plan:
- Reset: assert rstn=0 mid-BUSY with mw_vld_m=1 -> mw_vld_m=0, pc_vld_m=0, a_q=d_q=0 immediately; rdy_s=1 after release.
- A-instruction: imm_s=1, out_s=0x1234, pc_s=5 -> a_q=0x1234 next cycle; pc_m=6, pc_vld_m=1; no mw_vld_m.
- M write with A update:
  - Setup: a_q=0x0010; accept dst=3'b101, out_s=0x00FF.
  - Expect: mw_addr_m=0x0010, mw_data_m=0x00FF, a_q=0x00FF.
  - Hold mw_rdy_m=0 for 3 cycles -> outputs stable, rdy_s=0 until acked.
- Jumps with a_q=0x0040, pc_s=0x7FFF:
  - jmp=3'b010 with zr_s=1 -> pc_m=0x0040.
  - jmp=3'b100 with ng_s=0, zr_s=1 -> pc_m=0x0000 (wrap).
  - jmp=3'b111 -> always 0x0040.
- Handshake ordering: pc_rdy_m acks first, mw_rdy_m two cycles later, and the same-cycle variant -> state IDLE one edge after the last ack in both cases.
- Overflow: accept with of_s=1 -> of_sticky=1 and stays 1 across 3 further instructions; of_clr pulse -> 0; of_clr coincident with new of_s=1 -> remains 1.
